// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle control FSM for the 3-bit-opcode datapath.
// It sequences fetch, decode, execute, memory and write-back, and handshakes with a
// variable-latency memory. Moore outputs are decoded from the state. Two outputs are Mealy:
// the FETCH load enables and the BRANCH pc_write.
module mc_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_read,
  output logic       mem_write,
  output logic       iord,
  output logic       ir_write,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       halted,
  output logic       illegal,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,  S_DECODE = 4'd1, S_MEMADR = 4'd2, S_MEMRD = 4'd3,
    S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5, S_EXEC   = 4'd6, S_RWB   = 4'd7,
    S_BRANCH = 4'd8,  S_JUMP   = 4'd9, S_HALT   = 4'd10
  } st_t;

  st_t  cur, nxt;
  logic ill_q;

  // state register; reset lands directly in FETCH
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cur <= S_FETCH;
    else        cur <= nxt;
  end

  // sticky illegal-opcode flag, set when DECODE sees 110/111
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                              ill_q <= 1'b0;
    else if (cur == S_DECODE && op[2:1] == 2'b11) ill_q <= 1'b1;
  end

  // next-state: memory states stall on mem_ready, DECODE dispatches on op
  always_comb begin
    nxt = S_FETCH;
    case (cur)
      S_FETCH:  nxt = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          3'b000:         nxt = S_HALT;
          3'b001:         nxt = S_EXEC;
          3'b010, 3'b011: nxt = S_MEMADR;
          3'b100:         nxt = S_BRANCH;
          3'b101:         nxt = S_JUMP;
          default:        nxt = S_FETCH;
        endcase
      end
      S_MEMADR: nxt = (op == 3'b011) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  nxt = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWB:  nxt = S_FETCH;
      S_MEMWR:  nxt = mem_ready ? S_FETCH : S_MEMWR;
      S_EXEC:   nxt = S_RWB;
      S_RWB:    nxt = S_FETCH;
      S_BRANCH: nxt = S_FETCH;
      S_JUMP:   nxt = S_FETCH;
      S_HALT:   nxt = S_HALT;
      default:  nxt = S_FETCH;
    endcase
  end

  // per-state control decode; FETCH enables are gated by rst_n so reset never writes
  always_comb begin
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 2'b00;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    halted     = 1'b0;
    case (cur)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready & rst_n;
        pc_write  = mem_ready & rst_n;
      end
      S_DECODE: alu_src_b = 2'b11;
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
      end
      S_RWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b01;
        pc_src    = 2'b01;
        pc_write  = zero;
      end
      S_JUMP: begin
        pc_src   = 2'b10;
        pc_write = 1'b1;
      end
      S_HALT:  halted = 1'b1;
      default: ;
    endcase
  end

  assign illegal = ill_q;
  assign state   = cur;

endmodule
